// File: rtl/exc_seq.sv
// Exception/interrupt entry-and-return sequencer.
// Sits between CP0 and pipeline control: waits for the data bus to go idle,
// then strobes CP0 EXL set/clear, flushes the pipeline and redirects the PC
// to the handler (entry) or to EPC (ERET). Keeps a saturating entry count.
//
// Handshake note: redirect_valid is a one-cycle valid with no ready; the PC
// logic must load redirect_pc in every cycle redirect_valid is high, and
// redirect_pc is only meaningful in those cycles (it reads 0 otherwise).
module exc_seq #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int          DRAIN_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             int_req,
  input  logic             is_eret_M,
  input  logic             mem_busy,
  input  logic [31:0]      epc,
  output logic             exl_set,
  output logic             exl_clr,
  output logic             flush_all,
  output logic             hold_pipe,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] exc_count,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ENTER = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ERET  = 3'd4;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [3:0]       drain_cnt;
  logic [31:0]      epc_q;
  logic [CNT_W-1:0] cnt_q;

  // Next-state decode; requests are only looked at while in RUN.
  always_comb begin
    next_state = state;
    case (state)
      S_RUN: begin
        // ERET wins: CP0 also raises IntReq while an ERET is in M.
        if (is_eret_M)     next_state = S_ERET;
        else if (int_req)  next_state = mem_busy ? S_WAIT : S_ENTER;
        else               next_state = S_RUN;
      end
      // Request already committed; only the bus matters now.
      S_WAIT:  next_state = mem_busy ? S_WAIT : S_ENTER;
      S_ENTER: next_state = S_DRAIN;
      // <= 1 also guards against a zero count ever sticking in DRAIN.
      S_DRAIN: next_state = (drain_cnt <= 4'd1) ? S_RUN : S_DRAIN;
      S_ERET:  next_state = S_RUN;
      default: next_state = S_RUN;
    endcase
  end

  // State, drain counter, captured EPC and saturating entry counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      drain_cnt <= 4'd0;
      epc_q     <= 32'd0;
      cnt_q     <= '0;
    end else begin
      state <= next_state;
      if (state == S_RUN && is_eret_M)
        epc_q <= {epc[31:2], 2'b00};
      if (state == S_ENTER)
        drain_cnt <= DRAIN_LOAD;
      else if (state == S_DRAIN)
        drain_cnt <= drain_cnt - 4'd1;
      if (state == S_ENTER && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Moore outputs decoded from state only.
  assign exl_set        = (state == S_ENTER);
  assign exl_clr        = (state == S_ERET);
  assign flush_all      = (state == S_ENTER) || (state == S_DRAIN) || (state == S_ERET);
  assign hold_pipe      = (state == S_WAIT);
  assign redirect_valid = (state == S_ENTER) || (state == S_ERET);
  assign redirect_pc    = (state == S_ENTER) ? HANDLER_PC :
                          (state == S_ERET)  ? epc_q      : 32'd0;
  assign busy           = (state != S_RUN);
  assign exc_count      = cnt_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: directed vectors, redirect events checked by a monitor
// against an expected queue, per-cycle control outputs checked inline.
module tb_exc_seq;

  localparam logic [2:0] S_RUN = 3'd0;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req, is_eret_M, mem_busy;
  logic [31:0] epc;

  logic        exl_set, exl_clr, flush_all, hold_pipe, redirect_valid, busy;
  logic [31:0] redirect_pc;
  logic [15:0] exc_count;
  logic [2:0]  state_dbg;

  logic        s_exl_set, s_exl_clr, s_flush_all, s_hold_pipe, s_redirect_valid, s_busy;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_exc_count;
  logic [2:0]  s_state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  // {exl_set, exl_clr, flush_all, redirect_pc}
  logic [34:0] exp_q[$];

  exc_seq #(.HANDLER_PC(HPC), .DRAIN_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .int_req(int_req), .is_eret_M(is_eret_M),
    .mem_busy(mem_busy), .epc(epc), .exl_set(exl_set), .exl_clr(exl_clr),
    .flush_all(flush_all), .hold_pipe(hold_pipe), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy), .exc_count(exc_count),
    .state_dbg(state_dbg)
  );

  exc_seq #(.HANDLER_PC(HPC), .DRAIN_CYCLES(2), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .int_req(int_req), .is_eret_M(is_eret_M),
    .mem_busy(mem_busy), .epc(epc), .exl_set(s_exl_set), .exl_clr(s_exl_clr),
    .flush_all(s_flush_all), .hold_pipe(s_hold_pipe), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .busy(s_busy), .exc_count(s_exc_count),
    .state_dbg(s_state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_enter();
    exp_q.push_back({1'b1, 1'b0, 1'b1, HPC});
  endtask

  // Drain phase of an entry: two flush-only cycles, then back in RUN.
  task automatic check_drain(input string tag);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk({tag, "_drain_flush"}, 32'(flush_all), 32'd1);
      chk({tag, "_drain_rv"},    32'(redirect_valid), 32'd0);
      chk({tag, "_drain_set"},   32'(exl_set), 32'd0);
      chk({tag, "_drain_busy"},  32'(busy), 32'd1);
    end
    tick();
    chk({tag, "_run_busy"},  32'(busy), 32'd0);
    chk({tag, "_run_flush"}, 32'(flush_all), 32'd0);
  endtask

  // Scoreboard monitor: every redirect the DUT presents must match the queue.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if ((exl_set && exl_clr) || (redirect_valid && !flush_all)) begin
        n_fail++;
        $display("FAIL invariant: exl_set=%0b exl_clr=%0b rv=%0b flush=%0b",
                 exl_set, exl_clr, redirect_valid, flush_all);
      end
      if (redirect_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL redirect_unexpected: got pc 0x%08h expected none", redirect_pc);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          if ({exl_set, exl_clr, flush_all, redirect_pc} !== e) begin
            n_fail++;
            $display("FAIL redirect: got set=%0b clr=%0b fl=%0b pc=0x%08h expected set=%0b clr=%0b fl=%0b pc=0x%08h",
                     exl_set, exl_clr, flush_all, redirect_pc, e[34], e[33], e[32], e[31:0]);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    reset = 1'b1; int_req = 1'b0; is_eret_M = 1'b0; mem_busy = 1'b0; epc = 32'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", 32'(state_dbg), 32'(S_RUN));
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_pc",    redirect_pc, 32'd0);
    chk("rst_cnt",   32'(exc_count), 32'd0);

    // Reset held 2 cycles in the middle of DRAIN.
    int_req = 1'b1; push_enter();
    tick();                       // ENTER
    int_req = 1'b0;
    tick();                       // DRAIN
    chk("pre_rst_drain", 32'(flush_all), 32'd1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("drst_state", 32'(state_dbg), 32'(S_RUN));
    chk("drst_flush", 32'(flush_all), 32'd0);
    chk("drst_busy",  32'(busy), 32'd0);
    chk("drst_rv",    32'(redirect_valid), 32'd0);
    chk("drst_cnt",   32'(exc_count), 32'd0);
    chk("drst_scnt",  32'(s_exc_count), 32'd0);

    // Plain entry, bus idle.
    tick();
    int_req = 1'b1; push_enter();
    tick();                       // ENTER
    chk("plain_set",  32'(exl_set), 32'd1);
    chk("plain_hold", 32'(hold_pipe), 32'd0);
    int_req = 1'b0;
    check_drain("plain");
    chk("plain_cnt", 32'(exc_count), 32'd1);

    // Bus wait: mem_busy high for the request cycle and two more.
    int_req = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      int_req = 1'b0;             // not rechecked once committed
      chk("wait_hold",  32'(hold_pipe), 32'd1);
      chk("wait_set",   32'(exl_set), 32'd0);
      chk("wait_flush", 32'(flush_all), 32'd0);
    end
    mem_busy = 1'b0; push_enter();
    tick();                       // ENTER
    chk("wait_enter", 32'(exl_set), 32'd1);
    chk("wait_hold_off", 32'(hold_pipe), 32'd0);
    check_drain("wait");
    chk("wait_cnt",  32'(exc_count), 32'd2);
    chk("wait_scnt", 32'(s_exc_count), 32'd2);

    // ERET priority over int_req; EPC low bits cleared.
    is_eret_M = 1'b1; int_req = 1'b1; epc = 32'h0000_3007;
    exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0000_3004});
    tick();                       // ERET
    is_eret_M = 1'b0; int_req = 1'b0; epc = 32'hFFFF_FFFF;
    chk("eret_clr", 32'(exl_clr), 32'd1);
    chk("eret_set", 32'(exl_set), 32'd0);
    chk("eret_pc",  redirect_pc, 32'h0000_3004);
    tick();
    chk("eret_run",  32'(busy), 32'd0);
    chk("eret_cnt",  32'(exc_count), 32'd2);

    // Pulse during DRAIN is ignored.
    int_req = 1'b1; push_enter();
    tick();                       // ENTER
    int_req = 1'b0;
    tick();                       // DRAIN 1
    int_req = 1'b1;
    tick();                       // DRAIN 2 (request ignored)
    int_req = 1'b0;
    tick();                       // RUN
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_set",  32'(exl_set), 32'd0);
    tick();
    chk("ign_idle", 32'(busy), 32'd0);
    chk("ign_cnt",  32'(exc_count), 32'd3);

    // Request held through DRAIN re-enters once back in RUN.
    int_req = 1'b1; push_enter(); push_enter();
    tick();                       // ENTER
    tick(); tick();               // DRAIN x2
    tick();                       // RUN, request sampled here
    chk("held_run", 32'(busy), 32'd0);
    tick();                       // second ENTER
    int_req = 1'b0;
    chk("held_enter", 32'(exl_set), 32'd1);
    check_drain("held");
    chk("held_cnt",  32'(exc_count), 32'd5);
    chk("sat_cnt",   32'(s_exc_count), 32'd3);

    tick(); tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
